// File: rtl/aes128_inv_shift_rows_seq.sv
// Byte-serial (Inv)ShiftRows buffer: fills 16 bytes, then drains them in permuted order.
// Define AES128_ISR_FWD_EN to add mode_i, which selects the forward ShiftRows permutation.
module aes128_inv_shift_rows_seq #(
   parameter int TAG_W = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [7:0]       in_data_i,
   input  logic [TAG_W-1:0] in_tag_i,
`ifdef AES128_ISR_FWD_EN
   input  logic             mode_i,
`endif
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [7:0]       out_data_o,
   output logic [TAG_W-1:0] out_tag_o,
   output logic             out_last_o,
   input  logic             clear_i,
   output logic             busy_o
);

   localparam logic [0:0] FILL  = 1'b0;
   localparam logic [0:0] DRAIN = 1'b1;

   logic [0:0]       state;
   logic [3:0]       cnt;
   logic [7:0]       buf_mem [16];
   logic [TAG_W-1:0] tag_q;
   logic             fwd;
   logic             accept;
   logic             xfer;
   logic [1:0]       col;
   logic [1:0]       row;
   logic [1:0]       src_col;

   assign accept = (state == FILL) && in_valid_i;
   assign xfer   = (state == DRAIN) && out_ready_i;

   // clear_i wins over any handshake in the same cycle; the offered byte is dropped
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= FILL;
         cnt   <= 4'd0;
         tag_q <= '0;
      end else if (clear_i) begin
         state <= FILL;
         cnt   <= 4'd0;
      end else if (accept) begin
         if (cnt == 4'd0) tag_q <= in_tag_i;
         cnt <= cnt + 4'd1;
         if (cnt == 4'd15) state <= DRAIN;
      end else if (xfer) begin
         cnt <= cnt + 4'd1;
         if (cnt == 4'd15) state <= FILL;
      end
   end

`ifdef AES128_ISR_FWD_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fwd <= 1'b0;
      end else if (!clear_i && accept && (cnt == 4'd0)) begin
         fwd <= mode_i;
      end
   end
`else
   assign fwd = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (accept && !clear_i) buf_mem[cnt] <= in_data_i;
   end

   // Output index j = col*4 + row reads column (col -/+ row) mod 4 of the same row
   assign col     = cnt[3:2];
   assign row     = cnt[1:0];
   assign src_col = fwd ? (col + row) : (col - row);

   assign in_ready_o  = (state == FILL);
   assign out_valid_o = (state == DRAIN);
   assign out_data_o  = (state == DRAIN) ? buf_mem[{src_col, row}] : 8'h00;
   assign out_tag_o   = tag_q;
   assign out_last_o  = (state == DRAIN) && (cnt == 4'd15);
   assign busy_o      = !((state == FILL) && (cnt == 4'd0));

endmodule

// File: tb/tb_aes128_inv_shift_rows_seq.sv
// Self-checking bench for aes128_inv_shift_rows_seq: directed blocks plus random blocks
// compared against a row-rotation model of (Inv)ShiftRows.
module tb_aes128_inv_shift_rows_seq;

   localparam int TAG_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [7:0]       in_data = 8'h00;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [7:0]       out_data;
   logic [TAG_W-1:0] out_tag;
   logic             out_last;
   logic             clear = 1'b0;
   logic             busy;
`ifdef AES128_ISR_FWD_EN
   logic             mode = 1'b0;
`endif

   int compared   = 0;
   int mismatched = 0;
   int accepts    = 0;

   aes128_inv_shift_rows_seq #(.TAG_W(TAG_W)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .in_valid_i(in_valid),
      .in_ready_o(in_ready),
      .in_data_i(in_data),
      .in_tag_i(in_tag),
`ifdef AES128_ISR_FWD_EN
      .mode_i(mode),
`endif
      .out_valid_o(out_valid),
      .out_ready_i(out_ready),
      .out_data_o(out_data),
      .out_tag_o(out_tag),
      .out_last_o(out_last),
      .clear_i(clear),
      .busy_o(busy)
   );

   always #5 clk = ~clk;

   // Model: lay the block out as a 4x4 matrix and rotate row r by r positions
   function automatic logic [127:0] ref_model(input logic [127:0] blk, input bit fwd_mode);
      logic [7:0]   q[$];
      logic [127:0] res;
      res = '0;
      for (int r = 0; r < 4; r++) begin
         q.delete();
         for (int c = 0; c < 4; c++) q.push_back(blk[(c*4+r)*8 +: 8]);
         for (int k = 0; k < r; k++) begin
            if (fwd_mode) q.push_back(q.pop_front());
            else          q.push_front(q.pop_back());
         end
         for (int c = 0; c < 4; c++) res[(c*4+r)*8 +: 8] = q[c];
      end
      return res;
   endfunction

   function automatic logic [127:0] rand_block();
      logic [127:0] b;
      for (int k = 0; k < 4; k++) b[k*32 +: 32] = $urandom;
      return b;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // Offer the first n bytes of blk, one per cycle; entered and left on a falling edge
   task automatic applyStimulus(input logic [127:0] blk, input logic [TAG_W-1:0] tag,
                                input bit fwd_mode, input int n, input bit hold_valid);
      for (int k = 0; k < n; k++) begin
         in_valid = 1'b1;
         in_data  = blk[k*8 +: 8];
         in_tag   = (k == 0) ? tag : TAG_W'($urandom);
`ifdef AES128_ISR_FWD_EN
         mode     = (k == 0) ? fwd_mode : 1'($urandom);
`else
         if (fwd_mode) $display("[TB] forward mode requested without AES128_ISR_FWD_EN");
`endif
         checkOutput("fill_in_ready", 32'(in_ready), 32'd1);
         checkOutput("fill_out_valid", 32'(out_valid), 32'd0);
         if (in_ready) accepts++;
         @(negedge clk);
      end
      in_valid = hold_valid;
      in_data  = 8'($urandom);
      in_tag   = TAG_W'($urandom);
   endtask

   task automatic drainBlock(input logic [127:0] exp, input logic [TAG_W-1:0] exp_tag,
                             input int n, input bit toggle, input bit stall);
      int j = 0;
      int cyc = 0;
      int stall_left = stall ? 5 : 0;
      while (j < n && cyc < 200) begin
         if (stall && j == 7 && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
         end else begin
            out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
         end
         checkOutput("drain_out_valid", 32'(out_valid), 32'd1);
         checkOutput("drain_in_ready", 32'(in_ready), 32'd0);
         checkOutput("drain_busy", 32'(busy), 32'd1);
         checkOutput("drain_data", 32'(out_data), 32'(exp[j*8 +: 8]));
         checkOutput("drain_tag", 32'(out_tag), 32'(exp_tag));
         checkOutput("drain_last", 32'(out_last), 32'(j == 15));
         if (out_ready && out_valid) j++;
         cyc++;
         @(negedge clk);
      end
      out_ready = 1'b0;
      checkOutput("drain_count", 32'(j), 32'(n));
   endtask

   task automatic checkIdle(input string name);
      checkOutput({name, "_out_valid"}, 32'(out_valid), 32'd0);
      checkOutput({name, "_in_ready"}, 32'(in_ready), 32'd1);
      checkOutput({name, "_busy"}, 32'(busy), 32'd0);
      checkOutput({name, "_last"}, 32'(out_last), 32'd0);
   endtask

   initial begin
      logic [127:0]     seq_blk;
      logic [127:0]     inv_const;
      logic [127:0]     blk_a;
      logic [127:0]     blk_b;
      logic [TAG_W-1:0] tag_a;
      logic [TAG_W-1:0] tag_b;

      inv_const = 128'h0306090C_0F020508_0B0E0104_070A0D00;
      for (int k = 0; k < 16; k++) seq_blk[k*8 +: 8] = 8'(k);

      repeat (2) @(negedge clk);
      checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_last", 32'(out_last), 32'd0);
      checkOutput("reset_data", 32'(out_data), 32'h00);
      checkOutput("reset_tag", 32'(out_tag), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] sequential block, ready held high");
      applyStimulus(seq_blk, 4'h5, 1'b0, 16, 1'b0);
      drainBlock(inv_const, 4'h5, 16, 1'b0, 1'b0);
      checkIdle("after_seq");

      $display("[TB] sequential block, toggling ready with stall at byte 7");
      applyStimulus(seq_blk, 4'h5, 1'b0, 16, 1'b0);
      drainBlock(inv_const, 4'h5, 16, 1'b1, 1'b1);
      checkIdle("after_stall");

      $display("[TB] partial block flushed by clear");
      applyStimulus(rand_block(), 4'hA, 1'b0, 9, 1'b0);
      in_valid = 1'b1;
      in_data  = 8'hEE;
      clear    = 1'b1;
      @(negedge clk);
      clear    = 1'b0;
      in_valid = 1'b0;
      checkIdle("after_clear");
      for (int k = 0; k < 16; k++) blk_a[k*8 +: 8] = 8'(8'h10 + k);
      applyStimulus(blk_a, 4'h3, 1'b0, 16, 1'b0);
      drainBlock(inv_const | {16{8'h10}}, 4'h3, 16, 1'b0, 1'b0);
      checkIdle("after_clear_block");

      $display("[TB] asynchronous reset in the middle of draining");
      blk_a = rand_block();
      tag_a = TAG_W'($urandom);
      applyStimulus(blk_a, tag_a, 1'b0, 16, 1'b0);
      drainBlock(ref_model(blk_a, 1'b0), tag_a, 4, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      checkOutput("async_rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("async_rst_data", 32'(out_data), 32'h00);
      checkOutput("async_rst_tag", 32'(out_tag), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkIdle("after_async_rst");
      blk_a = rand_block();
      tag_a = TAG_W'($urandom);
      applyStimulus(blk_a, tag_a, 1'b0, 16, 1'b0);
      drainBlock(ref_model(blk_a, 1'b0), tag_a, 16, 1'b1, 1'b0);
      checkIdle("after_rst_block");

      $display("[TB] back-to-back blocks with in_valid held high");
      accepts = 0;
      blk_a = rand_block();
      blk_b = rand_block();
      tag_a = 4'h9;
      tag_b = 4'h6;
      applyStimulus(blk_a, tag_a, 1'b0, 16, 1'b1);
      drainBlock(ref_model(blk_a, 1'b0), tag_a, 16, 1'b0, 1'b0);
      applyStimulus(blk_b, tag_b, 1'b0, 16, 1'b1);
      drainBlock(ref_model(blk_b, 1'b0), tag_b, 16, 1'b0, 1'b0);
      in_valid = 1'b0;
      checkOutput("b2b_accepts", 32'(accepts), 32'd32);
      checkIdle("after_b2b");

`ifdef AES128_ISR_FWD_EN
      $display("[TB] forward mode on the sequential block");
      applyStimulus(seq_blk, 4'hC, 1'b1, 16, 1'b0);
      drainBlock(128'h0B06010C_07020D08_030E0904_0F0A0500, 4'hC, 16, 1'b0, 1'b0);
      applyStimulus(seq_blk, 4'hD, 1'b0, 16, 1'b0);
      drainBlock(inv_const, 4'hD, 16, 1'b0, 1'b0);
      checkIdle("after_fwd");
`endif

      $display("[TB] random blocks");
      for (int t = 0; t < 6; t++) begin
         bit fwd_mode;
`ifdef AES128_ISR_FWD_EN
         fwd_mode = 1'($urandom);
`else
         fwd_mode = 1'b0;
`endif
         blk_a = rand_block();
         tag_a = TAG_W'($urandom);
         applyStimulus(blk_a, tag_a, fwd_mode, 16, 1'b0);
         drainBlock(ref_model(blk_a, fwd_mode), tag_a, 16, 1'(t % 2), 1'b0);
      end
      checkIdle("after_random");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/aes128_inv_shift_rows_seq.md
Name: aes128_inv_shift_rows_seq

Overview:
- Byte-serial InvShiftRows unit for the decryption datapath of the AES-128 peripheral.
- Accepts a 16-byte state one byte per handshake and buffers it internally.
- Emits the 16 bytes in inverse-ShiftRows order over a valid/ready stream.
- Sits between the bus-facing byte register and the inverse S-box stage; carries an optional sideband tag through with each block.

Parameters:
TAG_W, 4, width of sideband tag captured with byte 0 and returned with every output byte (min 1)

Ports:
clk_i  input  1  clock; all state on rising edge
rst_i  input  1  asynchronous, active-high reset
in_valid_i  input  1  input byte valid
in_ready_o  output  1  unit can accept input byte
in_data_i  input  8  input state byte; k-th accepted byte is state index k
in_tag_i  input  TAG_W  tag, sampled only on acceptance of byte 0
out_valid_o  output  1  output byte valid
out_ready_i  input  1  downstream accepts output byte
out_data_o  output  8  output state byte, index j in order 0..15
out_tag_o  output  TAG_W  tag of block being drained
out_last_o  output  1  high with output byte 15
clear_i  input  1  synchronous flush: discard partial/full block
busy_o  output  1  high when not (FILL with count 0)

Behaviour:
- State indexing: index i = col*4 + row; byte i is bits [i*8+:8] of the 128-bit state used elsewhere in the core.
- Buffer: 16 x 8 register file; 4-bit counter cnt; FSM states FILL, DRAIN.
- Reset (async, rst_i=1):
  - state=FILL, cnt=0, in_ready_o=1, out_valid_o=0, out_last_o=0.
  - out_data_o=0x00, out_tag_o=0, busy_o=0.
  - Buffer contents don't-care.
- FILL:
  - in_ready_o=1, out_valid_o=0.
  - On in_valid_i & in_ready_o: buf[cnt]<=in_data_i; cnt<=cnt+1; if cnt==0 capture in_tag_i.
  - At cnt==15 acceptance: cnt wraps to 0, state<=DRAIN; out_valid_o=1 on the next cycle. Latency: last input accept edge -> out_valid_o high 1 cycle later.
- DRAIN:
  - in_ready_o=0, out_valid_o=1.
  - out_data_o = buf[src(cnt)], combinational from registered buffer/cnt.
  - Inverse mapping: c=cnt[3:2], r=cnt[1:0], src = ((c - r) mod 4)*4 + r.
  - On out_valid_o & out_ready_i: cnt<=cnt+1.
  - At cnt==15 transfer: cnt<=0, state<=FILL.
  - out_last_o = (cnt==15) in DRAIN.
  - out_valid_o stays high and out_data_o/out_tag_o stay stable while out_ready_i=0.
- Throughput: 32 cycles per block minimum. No overlap of FILL and DRAIN; single buffer.
- clear_i (sync): next edge state<=FILL, cnt<=0. clear_i overrides any simultaneous handshake, and the byte offered that cycle is dropped. In FILL with cnt==0 it is a no-op.
- Reset mid-block (either state): block is discarded and the unit returns to the reset values above.
- in_valid_i in DRAIN is ignored (no acceptance); out_ready_i in FILL is ignored.
- in_data_i/in_tag_i X while in_valid_i=0 must not corrupt state.

Optional Feature:
- Macro: AES128_ISR_FWD_EN.
- Defined:
  - Adds input port mode_i (1 bit), sampled with byte 0 and held for the block.
  - mode_i=1 selects forward ShiftRows: src = ((c + r) mod 4)*4 + r.
  - mode_i=0 selects inverse.
- Undefined: no mode_i port; always inverse.

Test Plan:
- Reset, then stream bytes 0x00..0x0F, tag 0x5, out_ready_i=1 -> output 00 0D 0A 07 04 01 0E 0B 08 05 02 0F 0C 09 06 03; out_tag_o=0x5 throughout; out_last_o only on byte 15; out_valid_o first high exactly 1 cycle after 16th accept.
- Same block with out_ready_i toggling 1/0 each cycle plus a 5-cycle stall at j=7 -> identical byte sequence; out_data_o holds 0x0B stable during the stall; in_ready_o=0 throughout DRAIN.
- Feed 9 bytes, pulse clear_i together with in_valid_i on byte 10, then feed 0x10..0x1F -> output 10 1D 1A 17 14 11 1E 1B 18 15 12 1F 1C 19 16 13; no stale bytes emitted.
- Assert rst_i asynchronously (mid-cycle) at DRAIN j=4 -> out_valid_o drops immediately; in_ready_o=1, busy_o=0 after release; next block processes correctly.
- Two back-to-back blocks with in_valid_i held high -> exactly 16 accepts per block, in_ready_o low for 16 DRAIN transfers between blocks, each tag returned with its own block.
- With AES128_ISR_FWD_EN, mode_i=1, bytes 0x00..0x0F -> 00 05 0A 0F 04 09 0E 03 08 0D 02 07 0C 01 06 0B; with mode_i=0 -> inverse sequence above.
